// File: rtl/ucaspian_step_sched_if.sv
// Scheduler-facing bundle: run request handshake, step/clear handshakes with the units,
// and the global time/status outputs.
interface ucaspian_step_sched_if #(
    parameter int NUM_UNITS = 3,
    parameter int STEP_W    = 16,
    parameter int TIME_W    = 32
);
    logic                 enable;
    logic [STEP_W-1:0]    run_steps;
    logic                 run_vld;
    logic                 run_rdy;
    logic                 clear_act_req;
    logic                 clear_act;
    logic [NUM_UNITS-1:0] clear_done;
    logic                 next_step;
    logic [NUM_UNITS-1:0] step_done;
    logic [TIME_W-1:0]    time_now;
    logic [STEP_W-1:0]    steps_left;
    logic                 busy;
    logic                 run_done;

    modport master (
        output enable, run_steps, run_vld, clear_act_req, clear_done, step_done,
        input  run_rdy, clear_act, next_step, time_now, steps_left, busy, run_done
    );

    modport slave (
        input  enable, run_steps, run_vld, clear_act_req, clear_done, step_done,
        output run_rdy, clear_act, next_step, time_now, steps_left, busy, run_done
    );
endinterface

// File: rtl/ucaspian_step_sched.sv
// uCaspian time-step scheduler: issues next_step pulses, waits for all units to finish
// each step, counts global time and runs the activity-clear handshake.
module ucaspian_step_sched #(
    parameter int NUM_UNITS = 3,
    parameter int STEP_W    = 16,
    parameter int TIME_W    = 32,
    parameter int SETTLE    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    ucaspian_step_sched_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_SETTLE, S_WAIT, S_DONE, S_CLEAR
    } state_t;

    state_t               state_q, state_d;
    logic [TIME_W-1:0]    time_q, time_d;
    logic [STEP_W-1:0]    steps_left_q, steps_left_d;
    logic                 clear_pend_q, clear_pend_d;
    logic [NUM_UNITS-1:0] clr_seen_q, clr_seen_d;
    logic [3:0]           settle_cnt_q, settle_cnt_d;
    logic                 run_rdy;

    assign run_rdy = (state_q == S_IDLE) && !clear_pend_q && !bus.clear_act_req;

    assign bus.run_rdy    = run_rdy;
    assign bus.next_step  = (state_q == S_ISSUE);
    assign bus.clear_act  = (state_q == S_CLEAR);
    assign bus.run_done   = (state_q == S_DONE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.time_now   = time_q;
    assign bus.steps_left = steps_left_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            time_q       <= '0;
            steps_left_q <= '0;
            clear_pend_q <= 1'b0;
            clr_seen_q   <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            time_q       <= time_d;
            steps_left_q <= steps_left_d;
            clear_pend_q <= clear_pend_d;
            clr_seen_q   <= clr_seen_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        time_d       = time_q;
        steps_left_d = steps_left_q;
        clear_pend_d = clear_pend_q;
        clr_seen_d   = clr_seen_q;
        settle_cnt_d = settle_cnt_q;

        // A clear requested mid-run is deferred until the run has fully finished.
        if (bus.clear_act_req && (state_q != S_IDLE) && (state_q != S_CLEAR))
            clear_pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.clear_act_req || clear_pend_q) begin
                    state_d      = S_CLEAR;
                    clr_seen_d   = '0;
                    clear_pend_d = 1'b0;
                end else if (bus.run_vld && run_rdy) begin
                    steps_left_d = bus.run_steps;
                    state_d      = (bus.run_steps == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                time_d       = time_q + TIME_W'(1);
                steps_left_d = steps_left_q - STEP_W'(1);
                settle_cnt_d = 4'(SETTLE - 1);
                state_d      = S_SETTLE;
            end
            S_SETTLE: begin
                // step_done may still reflect the previous step here, so it is not looked at.
                if (settle_cnt_q == 4'd0)
                    state_d = S_WAIT;
                else
                    settle_cnt_d = settle_cnt_q - 4'd1;
            end
            S_WAIT: begin
                if (&bus.step_done) begin
                    if (steps_left_q == '0)
                        state_d = S_DONE;
                    else if (bus.enable)
                        state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_CLEAR: begin
                clr_seen_d = clr_seen_q | bus.clear_done;
                if (&(clr_seen_q | bus.clear_done)) begin
                    time_d       = '0;
                    steps_left_d = '0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
